// File: rtl/soc_sysinfo_pkg.sv
// Shared constants for the system-info register block.
// Offsets, CTRL bit indices and CAPS field positions.
package soc_sysinfo_pkg;

  localparam logic [3:0] OFF_ID      = 4'd0;
  localparam logic [3:0] OFF_TS      = 4'd1;
  localparam logic [3:0] OFF_CAPS    = 4'd2;
  localparam logic [3:0] OFF_SCRATCH = 4'd3;
  localparam logic [3:0] OFF_UP_LO   = 4'd4;
  localparam logic [3:0] OFF_UP_HI   = 4'd5;
  localparam logic [3:0] OFF_CTRL    = 4'd6;
  localparam logic [3:0] OFF_RSVD    = 4'd7;
  localparam logic [3:0] OFF_INFO0   = 4'd8;

  localparam int CTRL_CLR = 0;
  localparam int CTRL_OVF = 1;

  localparam int CAPS_NINFO_LSB = 0;
  localparam int CAPS_PRE_LSB   = 16;

  function automatic logic [31:0] be_merge(
    input logic [31:0] old,
    input logic [31:0] wdata,
    input logic [3:0]  be
  );
    logic [31:0] r;
    r = old;
    for (int i = 0; i < 4; i++) begin
      if (be[i]) r[8*i +: 8] = wdata[8*i +: 8];
    end
    return r;
  endfunction

endpackage

// File: rtl/soc_sysinfo_uptime.sv
// Free-running 64-bit uptime counter behind a prescaler.
// Clear beats any coincident tick or wrap.
module soc_sysinfo_uptime #(
  parameter int PRESCALE = 1
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        clr,
  input  logic        ovf_clr,
  output logic [63:0] count,
  output logic        ovf
);

  localparam int PW =
    (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PW-1:0] PRE_MAX =
    PW'(PRESCALE - 1);

  logic [PW-1:0] pre;
  logic [63:0]   cnt;
  logic          ovf_q;
  logic          tick;
  logic          wrap;

  assign tick  = (pre == PRE_MAX);
  assign wrap  = tick && (&cnt);
  assign count = cnt;
  assign ovf   = ovf_q;

  always_ff @(posedge clock) begin
    if (reset || clr) begin
      pre   <= '0;
      cnt   <= '0;
      ovf_q <= 1'b0;
    end else begin
      pre <= tick ? '0 : pre + 1'b1;
      if (tick) cnt <= cnt + 64'd1;
      // a fresh wrap outranks a same-cycle W1C
      if (ovf_clr) ovf_q <= 1'b0;
      if (wrap)    ovf_q <= 1'b1;
    end
  end

endmodule

// File: rtl/soc_sysinfo.sv
// System-info register block: IDs, caps, scratch, uptime, info words.
// Single-cycle read latency, no wait states.
module soc_sysinfo
  import soc_sysinfo_pkg::*;
#(
  parameter logic [31:0] SYSTEM_ID = 32'h0000_00A5,
  parameter logic [31:0] TIMESTAMP = 32'd0,
  parameter int          NUM_INFO  = 4,
  parameter logic [NUM_INFO*32-1:0] INFO_WORDS = '0,
  parameter int          PRESCALE  = 1
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [3:0]  address,
  input  logic        read,
  input  logic        write,
  input  logic [31:0] writedata,
  input  logic [3:0]  byteenable,
  output logic [31:0] readdata,
  output logic        readdatavalid
);

  localparam logic [31:0] CAPS =
    (32'(PRESCALE) << CAPS_PRE_LSB) |
    (32'(NUM_INFO) << CAPS_NINFO_LSB);

  logic [31:0] scratch;
  logic [31:0] shadow;
  logic [63:0] count;
  logic        ovf;
  logic        wr_ctrl;
  logic        clr;
  logic        ovf_clr;
  logic [31:0] rdata;
  logic [31:0] info [8];

  for (genvar k = 0; k < 8; k++) begin : g_info
    if (k < NUM_INFO) begin : g_on
      assign info[k] = INFO_WORDS[32*k +: 32];
    end else begin : g_off
      assign info[k] = '0;
    end
  end

  assign wr_ctrl = write && byteenable[0] &&
                   (address == OFF_CTRL);
  assign clr     = wr_ctrl && writedata[CTRL_CLR];
  assign ovf_clr = wr_ctrl && writedata[CTRL_OVF];

  soc_sysinfo_uptime #(
    .PRESCALE(PRESCALE)
  ) u_uptime (
    .clock  (clock),
    .reset  (reset),
    .clr    (clr),
    .ovf_clr(ovf_clr),
    .count  (count),
    .ovf    (ovf)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      scratch <= '0;
    end else if (write && address == OFF_SCRATCH) begin
      scratch <= be_merge(scratch, writedata, byteenable);
    end
  end

  // HI is snapshotted from the same pre-edge value LO returns
  always_ff @(posedge clock) begin
    if (reset) begin
      shadow <= '0;
    end else if (read && address == OFF_UP_LO) begin
      shadow <= count[63:32];
    end
  end

  always_comb begin
    rdata = '0;
    unique case (1'b1)
      (address == OFF_ID):      rdata = SYSTEM_ID;
      (address == OFF_TS):      rdata = TIMESTAMP;
      (address == OFF_CAPS):    rdata = CAPS;
      (address == OFF_SCRATCH): rdata = scratch;
      (address == OFF_UP_LO):   rdata = count[31:0];
      (address == OFF_UP_HI):   rdata = shadow;
      (address == OFF_CTRL):
        rdata = 32'(ovf) << CTRL_OVF;
      (address == OFF_RSVD):    rdata = '0;
      address[3]:               rdata = info[address[2:0]];
      default:                  rdata = '0;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      readdata      <= '0;
      readdatavalid <= 1'b0;
    end else begin
      readdatavalid <= read;
      if (read) readdata <= rdata;
    end
  end

endmodule
